// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encodings, reset-cause codes and the software
// reset key used by the reset sequencer and its testbench-visible outputs.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  localparam logic [7:0] SW_RST_KEY = 8'hA5;

  // A software request only counts when it carries the unlock key.
  function automatic logic sw_key_ok(input logic req, input logic [7:0] key);
    return req && (key == SW_RST_KEY);
  endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// btn_debounce: two-flop synchroniser for the raw active-low push button,
// followed by a consecutive-cycle debouncer. Emits a one-cycle registered
// pulse on each accepted press (debounced 1->0 transition).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync_meta;
  logic            sync_out;
  logic            level;
  logic [DB_W-1:0] db_cnt;

  // Bring the asynchronous button into the clock domain; idles released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
    end else begin
      sync_meta <= btn_n;
      sync_out  <= sync_meta;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else if (sync_out != level) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level  <= sync_out;
        db_cnt <= '0;
        press  <= ~sync_out;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
        press  <= 1'b0;
      end
    end else begin
      db_cnt <= '0;
      press  <= 1'b0;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges power-on, button, keyed software and (optionally)
// watchdog reset sources, stretches the request, releases peripherals before
// the core, and latches the cause of the last reset.
// Optional watchdog is built only when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STRETCH_CYCLES  = 64,
  parameter int RELEASE_GAP     = 16,
  parameter int WDT_CYCLES      = 16777216,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       sw_rst_req,
  input  logic [7:0] sw_key,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       periph_rst,
  output logic       core_rst,
  output logic [1:0] reset_cause,
  output logic       in_reset
);

  state_t           state;
  logic [CNT_W-1:0] seq_cnt;
  logic             btn_press;
  logic             sw_fire;
  logic             wdt_fire;
  logic             any_trig;
  logic [1:0]       trig_cause;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .press (btn_press)
  );

  assign sw_fire  = sw_key_ok(sw_rst_req, sw_key);
  assign any_trig = btn_press | wdt_fire | sw_fire;

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [CNT_W-1:0] wdt_cnt;

  // A kick in the terminal cycle wins over the timeout.
  assign wdt_fire = (state == RUN) && wdt_en && !wdt_kick &&
                    (wdt_cnt == CNT_W'(WDT_CYCLES - 1));

  // Watchdog counter: runs only while armed in RUN, cleared by kick, disarm or firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if ((state != RUN) || !wdt_en || wdt_kick || wdt_fire) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_wdt;

  assign wdt_fire   = 1'b0;
  assign unused_wdt = wdt_en ^ wdt_kick;
`endif

  // Resolve simultaneous triggers: button beats watchdog beats software.
  always_comb begin
    trig_cause = CAUSE_SW;
    if (btn_press) begin
      trig_cause = CAUSE_BTN;
    end else if (wdt_fire) begin
      trig_cause = CAUSE_WDT;
    end else begin
      trig_cause = CAUSE_SW;
    end
  end

  // Sequencer FSM with registered reset outputs and sticky cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ASSERT;
      seq_cnt     <= '0;
      periph_rst  <= 1'b1;
      core_rst    <= 1'b1;
      in_reset    <= 1'b1;
      reset_cause <= CAUSE_POR;
    end else if (any_trig) begin
      // Any trigger (re)starts a full stretch, even mid-sequence.
      state       <= ASSERT;
      seq_cnt     <= '0;
      periph_rst  <= 1'b1;
      core_rst    <= 1'b1;
      in_reset    <= 1'b1;
      reset_cause <= trig_cause;
    end else begin
      case (state)
        ASSERT: begin
          if (seq_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
            state      <= STAGGER;
            seq_cnt    <= '0;
            periph_rst <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        STAGGER: begin
          if (seq_cnt == CNT_W'(RELEASE_GAP - 1)) begin
            state    <= RUN;
            seq_cnt  <= '0;
            core_rst <= 1'b0;
            in_reset <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          seq_cnt <= '0;
        end
        default: begin
          state      <= ASSERT;
          seq_cnt    <= '0;
          periph_rst <= 1'b1;
          core_rst   <= 1'b1;
          in_reset   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed, scoreboard-checked bench for reset_sequencer
// using small timing parameters. Watchdog expectations follow
// RESET_SEQ_WATCHDOG_EN in the same way as the design.
module tb_reset_sequencer;

  localparam int STRETCH = 8;
  localparam int GAP     = 4;
  localparam int DEB     = 5;
  localparam int WDT     = 32;

  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_BTN = 2'b01;
  localparam logic [1:0] C_SW  = 2'b10;
  localparam logic [1:0] C_WDT = 2'b11;

  typedef struct packed {
    logic       p;
    logic       c;
    logic [1:0] cause;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       btn_n;
  logic       sw_rst_req;
  logic [7:0] sw_key;
  logic       wdt_en;
  logic       wdt_kick;
  logic       periph_rst;
  logic       core_rst;
  logic [1:0] reset_cause;
  logic       in_reset;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STRETCH),
    .RELEASE_GAP    (GAP),
    .WDT_CYCLES     (WDT),
    .CNT_W          (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .sw_rst_req (sw_rst_req),
    .sw_key     (sw_key),
    .wdt_en     (wdt_en),
    .wdt_kick   (wdt_kick),
    .periph_rst (periph_rst),
    .core_rst   (core_rst),
    .reset_cause(reset_cause),
    .in_reset   (in_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: queue the expectation, advance past the edge, pop and compare.
  task automatic tick(input logic ep, input logic ec, input logic [1:0] ecause, input string tag);
    exp_t e;
    exp_q.push_back({ep, ec, ecause});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    vectors++;
    assert ({periph_rst, core_rst, in_reset, reset_cause} === {e.p, e.c, e.c, e.cause})
    else begin
      miscompares++;
      $error("FAIL %s: periph/core/in_reset/cause got %b/%b/%b/%b expected %b/%b/%b/%b",
             tag, periph_rst, core_rst, in_reset, reset_cause, e.p, e.c, e.c, e.cause);
    end
  endtask

  // Remaining ASSERT cycles, the STAGGER window, then the first RUN cycle.
  task automatic run_seq(input int n_assert, input logic [1:0] cause, input string tag);
    for (int i = 0; i < n_assert; i++) tick(1'b1, 1'b1, cause, tag);
    for (int i = 0; i < GAP; i++) tick(1'b0, 1'b1, cause, tag);
    tick(1'b0, 1'b0, cause, tag);
  endtask

  task automatic idle(input int n, input logic [1:0] cause, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, cause, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    btn_n       = 1'b1;
    sw_rst_req  = 1'b0;
    sw_key      = 8'h00;
    wdt_en      = 1'b0;
    wdt_kick    = 1'b0;

    // Power-on reset
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, C_POR, "por_hold");
    reset = 1'b0;
    run_seq(STRETCH - 1, C_POR, "por_seq");
    idle(3, C_POR, "por_run");

    // Wrong key ignored
    sw_rst_req = 1'b1; sw_key = 8'h5A;
    tick(1'b0, 1'b0, C_POR, "sw_badkey");
    sw_rst_req = 1'b0; sw_key = 8'h00;
    idle(3, C_POR, "sw_badkey_after");

    // Valid software reset
    sw_rst_req = 1'b1; sw_key = 8'hA5;
    tick(1'b1, 1'b1, C_SW, "sw_first");
    sw_rst_req = 1'b0; sw_key = 8'h00;
    run_seq(STRETCH - 1, C_SW, "sw_seq");

    // Button low one cycle short of the debounce window
    btn_n = 1'b0;
    idle(DEB - 1, C_SW, "btn_short");
    btn_n = 1'b1;
    idle(10, C_SW, "btn_short_after");

    // Bouncing button
    for (int i = 0; i < 12; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1'b0, 1'b0, C_SW, "btn_bounce");
    end
    btn_n = 1'b1;
    idle(8, C_SW, "btn_bounce_after");

    // Real press: 2 sync + 5 debounce cycles, press pulse, then FSM edge
    btn_n = 1'b0;
    idle(DEB, C_SW, "btn_press_wait");
    btn_n = 1'b1;
    idle(2, C_SW, "btn_press_wait2");
    tick(1'b1, 1'b1, C_BTN, "btn_first");
    // Restart from STAGGER with a software trigger
    for (int i = 0; i < STRETCH - 1; i++) tick(1'b1, 1'b1, C_BTN, "restart_assert");
    tick(1'b0, 1'b1, C_BTN, "restart_stag1");
    tick(1'b0, 1'b1, C_BTN, "restart_stag2");
    sw_rst_req = 1'b1; sw_key = 8'hA5;
    tick(1'b1, 1'b1, C_SW, "restart_first");
    sw_rst_req = 1'b0; sw_key = 8'h00;
    run_seq(STRETCH - 1, C_SW, "restart_seq");
    idle(DEB + 4, C_SW, "restart_run");

    // Priority: button press and valid software strobe in the same cycle
    btn_n = 1'b0;
    idle(DEB, C_SW, "prio_wait");
    btn_n = 1'b1;
    idle(2, C_SW, "prio_wait2");
    sw_rst_req = 1'b1; sw_key = 8'hA5;
    tick(1'b1, 1'b1, C_BTN, "prio_first");
    sw_rst_req = 1'b0; sw_key = 8'h00;
    run_seq(STRETCH - 1, C_BTN, "prio_seq");
    idle(DEB + 4, C_BTN, "prio_run");

    // Watchdog: kick every 20 cycles for 100 cycles
    wdt_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wdt_kick = 1'b1;
      tick(1'b0, 1'b0, C_BTN, "wdt_kick");
      wdt_kick = 1'b0;
      idle(19, C_BTN, "wdt_kicked");
    end
    wdt_kick = 1'b1;
    tick(1'b0, 1'b0, C_BTN, "wdt_last_kick");
    wdt_kick = 1'b0;
    idle(WDT - 1, C_BTN, "wdt_countdown");
`ifdef RESET_SEQ_WATCHDOG_EN
    tick(1'b1, 1'b1, C_WDT, "wdt_fire");
    wdt_en = 1'b0;
    run_seq(STRETCH - 1, C_WDT, "wdt_seq");
    idle(4, C_WDT, "wdt_run");
`else
    idle(2 * WDT, C_BTN, "wdt_absent");
    wdt_en = 1'b0;
`endif

    // Reset mid-sequence returns to POR values
    sw_rst_req = 1'b1; sw_key = 8'hA5;
    tick(1'b1, 1'b1, C_SW, "mid_first");
    sw_rst_req = 1'b0; sw_key = 8'h00;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, C_SW, "mid_assert");
    reset = 1'b1;
    tick(1'b1, 1'b1, C_POR, "mid_por");
    tick(1'b1, 1'b1, C_POR, "mid_por2");
    reset = 1'b0;
    run_seq(STRETCH - 1, C_POR, "mid_seq");
    idle(3, C_POR, "mid_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
